ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter (open-drain line control).
// Sequence: inhibit the clock, request to send, shift 8 data bits + odd parity
// on device falling edges, release for the stop bit, then check the device ACK.
// Optional build macro PS2_TX_TIMEOUT_EN adds a device-clock watchdog.
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);

    localparam int INH_N = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int INH_W = (INH_N > 1) ? $clog2(INH_N) : 1;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE
    } state_t;

    state_t             state, state_nx;
    logic               clk_s1, clk_s2, clk_prev;
    logic               data_s1, data_s2;
    logic               fall;
    logic [7:0]         shreg;
    logic               par;
    logic               bit_q;      // bit currently presented on the line
    logic [3:0]         edge_cnt;
    logic [INH_W-1:0]   inh_cnt;
    logic               inh_last;
    logic               accept;
    logic               timeout;

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign fall     = clk_prev && !clk_s2;
    assign inh_last = (state == INHIBIT) && (inh_cnt == INH_W'(INH_N - 1));

    // Two-flop synchronizers for the pad senses plus a delayed clock for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_N = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int WD_W = (WD_N > 1) ? $clog2(WD_N) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;

    // Watchdog runs from REQUEST onward; held clear until then and on each device edge
    assign wd_run  = (state != IDLE) && (state != INHIBIT);
    assign timeout = wd_run && !fall && (wd_cnt == WD_W'(WD_N - 1));

    // Watchdog counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (!wd_run || fall)
            wd_cnt <= '0;
        else if (!timeout)
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    // No watchdog: a silent device stalls the block until reset.
    // The expression is constant-false for any legal TIMEOUT_MS.
    assign timeout = (TIMEOUT_MS < 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Datapath: byte latch, inhibit timer, edge counter and presented bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            par      <= 1'b0;
            bit_q    <= 1'b1;
            edge_cnt <= '0;
            inh_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    inh_cnt <= '0;
                    if (accept) begin
                        shreg <= tx_data;
                        par   <= ~^tx_data;
                    end
                end
                INHIBIT: inh_cnt <= inh_cnt + 1'b1;
                REQUEST: begin
                    edge_cnt <= '0;
                    bit_q    <= 1'b0;           // start bit
                end
                SHIFT: begin
                    if (fall) begin
                        if (edge_cnt != 4'hF) edge_cnt <= edge_cnt + 4'd1;
                        // edge k (= edge_cnt+1) presents data bit k-1, then parity, then stop
                        if (edge_cnt < 4'd8)       bit_q <= shreg[edge_cnt[2:0]];
                        else if (edge_cnt == 4'd8) bit_q <= par;
                        else                       bit_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and line/pulse outputs
    always_comb begin
        state_nx    = state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = INHIBIT;
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_last) begin
                    ps2_data_oe = 1'b1;
                    state_nx    = REQUEST;
                end
            end
            REQUEST: begin
                ps2_data_oe = 1'b1;
                state_nx    = SHIFT;
            end
            SHIFT: begin
                ps2_data_oe = !bit_q;
                if (fall && edge_cnt == 4'd9) state_nx = ACK;
            end
            ACK: begin
                if (fall) begin
                    if (data_s2) begin
                        tx_error = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                    tx_done  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Watchdog expiry overrides everything: release lines, report error
        if (timeout) begin
            state_nx    = IDLE;
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            tx_done     = 1'b0;
            tx_error    = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple keyboard BFM on open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int H = 20;   // BFM half clock period in system cycles

    logic       clk, rst;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_done, tx_error, busy;
    logic       dev_clk, dev_data;          // 1 = device releases the line
    logic       clk_line, data_line;

    int checks = 0, errors = 0;
    int cyc_n = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, hs_cnt = 0;
    int done_cyc = 0, err_cyc = 0, hs_cyc = 0, last_fall = 0;
    int run = 0, run_both = 0, last_run = 0, last_both = 0, oe_hi = 0;
    logic watch = 1'b0;

    assign clk_line    = dev_clk & ~ps2_clk_oe;
    assign data_line   = dev_data & ~ps2_data_oe;
    assign ps2_clk_in  = clk_line;
    assign ps2_data_in = data_line;

    ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(100), .TIMEOUT_MS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_done(tx_done),
        .tx_error(tx_error), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // Event monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (tx_done)  begin done_cnt <= done_cnt + 1; done_cyc <= cyc_n; end
        if (tx_error) begin err_cnt  <= err_cnt + 1;  err_cyc  <= cyc_n; end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (tx_valid && tx_ready) begin hs_cnt <= hs_cnt + 1; hs_cyc <= cyc_n; end
        if (watch && ps2_data_oe) oe_hi <= oe_hi + 1;
        if (ps2_clk_oe) begin
            run      <= run + 1;
            run_both <= run_both + int'(ps2_data_oe);
        end else if (run != 0) begin
            last_run  <= run;
            last_both <= run_both;
            run       <= 0;
            run_both  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    // Keyboard BFM: waits for request-to-send, clocks nedges falling edges,
    // records the line before edge 1 and before each rising edge; edge 11 is the ACK.
    task automatic frame(input int nedges, input logic ack, output logic [10:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!(clk_line && !data_line) && t < 500) begin
            cyc(1);
            t++;
        end
        if (t >= 500) begin
            check("request_wait", 32'(t), 32'd0);
            return;
        end
        cyc(H);
        bits[0] = data_line;
        for (int k = 1; k <= nedges && k <= 10; k++) begin
            dev_clk   = 1'b0;
            last_fall = cyc_n;
            cyc(H);
            if (k == 1) watch = 1'b1;
            bits[k] = data_line;
            dev_clk = 1'b1;
            cyc(H);
        end
        watch = 1'b0;
        if (nedges > 10) begin
            if (ack) dev_data = 1'b0;
            cyc(4);
            dev_clk = 1'b0;
            cyc(H);
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            cyc(H);
        end
    endtask

    initial begin
        logic [10:0] bits;
        int d0, e0, h0, o0, t;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_ready",    32'(tx_ready),    32'd1);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_clk_oe",   32'(ps2_clk_oe),  32'd0);
        check("rst_data_oe",  32'(ps2_data_oe), 32'd0);
        check("rst_done",     32'(tx_done),     32'd0);
        check("rst_error",    32'(tx_error),    32'd0);
        cyc(3); rst = 1'b1; cyc(3);

        // 0xED with ACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        check("ed_busy", 32'(busy), 32'd1);
        frame(11, 1'b1, bits);
        cyc(2);
        check("ed_inhibit_len",  32'(last_run),  32'd100);
        check("ed_inhibit_data", 32'(last_both), 32'd1);
        check("ed_frame",        32'(bits),      32'(11'b11111011010));
        check("ed_done",         32'(done_cnt - d0), 32'd1);
        check("ed_no_error",     32'(err_cnt - e0),  32'd0);
        check("ed_ready",        32'(tx_ready),      32'd1);

        // 0x00: parity 1
        d0 = done_cnt;
        send(8'h00);
        frame(11, 1'b1, bits);
        cyc(2);
        check("z_frame",  32'(bits),        32'(11'b11000000000));
        check("z_parity", 32'(bits[9]),     32'd1);
        check("z_done",   32'(done_cnt - d0), 32'd1);

        // 0xFF: parity 1 on the line, data never driven low after start
        d0 = done_cnt; o0 = oe_hi;
        send(8'hFF);
        frame(11, 1'b1, bits);
        cyc(2);
        check("ff_frame", 32'(bits),          32'(11'b11111111110));
        check("ff_oe_lo", 32'(oe_hi - o0),    32'd0);
        check("ff_done",  32'(done_cnt - d0), 32'd1);

        // NACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        frame(11, 1'b0, bits);
        cyc(2);
        check("nack_error",   32'(err_cnt - e0),  32'd1);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        check("nack_ready",   32'(tx_ready),      32'd1);

        // Device stops clocking after bit 3
        d0 = done_cnt; e0 = err_cnt;
        send(8'h5A);
        frame(4, 1'b1, bits);
`ifdef PS2_TX_TIMEOUT_EN
        t = 0;
        while (err_cnt == e0 && t < 3000) begin cyc(1); t++; end
        cyc(1);
        check("to_error",   32'(err_cnt - e0), 32'd1);
        check("to_latency", 32'((err_cyc - last_fall) >= 998 && (err_cyc - last_fall) <= 1008), 32'd1);
        check("to_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("to_data_oe", 32'(ps2_data_oe), 32'd0);
        check("to_idle",    32'(busy),        32'd0);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
`else
        t = 0;
        cyc(1500);
        check("hang_busy",     32'(busy),          32'd1);
        check("hang_no_error", 32'(err_cnt - e0),  32'd0);
        rst = 1'b0; cyc(2); rst = 1'b1; cyc(2);
        check("hang_recover",  32'(tx_ready + t),  32'd1);
`endif

        // Reset mid-SHIFT at edge 5 (bit 4 of 0xA5 is 0, so data is driven)
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5);
        frame(4, 1'b1, bits);
        dev_clk = 1'b0;
        cyc(H / 2);
        check("mid_data_oe", 32'(ps2_data_oe), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("mid_rst_busy",    32'(busy),        32'd0);
        cyc(2);
        rst = 1'b1; dev_clk = 1'b1;
        cyc(10);
        check("mid_no_done",  32'(done_cnt - d0), 32'd0);
        check("mid_no_error", 32'(err_cnt - e0),  32'd0);
        d0 = done_cnt; o0 = oe_hi;
        send(8'hFF);
        frame(11, 1'b1, bits);
        cyc(2);
        check("post_rst_frame", 32'(bits),          32'(11'b11111111110));
        check("post_rst_done",  32'(done_cnt - d0), 32'd1);

        // tx_valid held high; second byte only after tx_done
        h0 = hs_cnt;
        tx_data = 8'h12; tx_valid = 1'b1;
        cyc(1);
        tx_data = 8'h34;
        frame(11, 1'b1, bits);
        tx_valid = 1'b0;
        check("b2b_first_frame", 32'(bits),            32'(11'b11000100100));
        check("b2b_handshakes",  32'(hs_cnt - h0),     32'd2);
        check("b2b_accept_slot", 32'(hs_cyc - done_cyc), 32'd1);
        frame(11, 1'b1, bits);
        cyc(2);
        check("b2b_second_frame", 32'(bits),     32'(11'b10001101000));
        check("b2b_inhibit_len",  32'(last_run), 32'd100);
        check("b2b_no_extra",     32'(hs_cnt - h0), 32'd2);

        check("never_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
